// File: rtl/matmult_pkg.sv
// matmult_pkg: shared types and helpers for the matmult_tile slice.
// Holds the controller state encoding, the saturating adder used by the MAC
// lanes when MATMULT_TILE_SAT_EN is defined, and the C-packing index helpers.
package matmult_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Widest accumulator the saturating adder supports
    localparam int SAT_MAX_W = 128;

    localparam logic signed [SAT_MAX_W:0] SAT_ONE = {{SAT_MAX_W{1'b0}}, 1'b1};

    // Signed add of two w-bit values (carried sign-extended in SAT_MAX_W bits),
    // clamped to [-2^(w-1), 2^(w-1)-1]. The caller keeps the low w bits.
    function automatic logic signed [SAT_MAX_W-1:0] sat_add(
        input logic signed [SAT_MAX_W-1:0] a,
        input logic signed [SAT_MAX_W-1:0] b,
        input int unsigned                 w
    );
        logic signed [SAT_MAX_W:0] sum;
        logic signed [SAT_MAX_W:0] hi;
        logic signed [SAT_MAX_W:0] lo;
        sum = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
        hi  = (SAT_ONE <<< (w - 32'd1)) - SAT_ONE;
        lo  = ~hi;
        if (sum > hi) begin
            sum = hi;
        end else if (sum < lo) begin
            sum = lo;
        end else begin
            sum = sum;
        end
        return sum[SAT_MAX_W-1:0];
    endfunction

    // Lane number of C[i][j] in the packed result
    function automatic int c_lane(input int i, input int j, input int n);
        return i * n + j;
    endfunction

    // Bit offset of C[i][j] in the packed result
    function automatic int c_lsb(input int i, input int j, input int n, input int acc_w);
        return c_lane(i, j, n) * acc_w;
    endfunction

endpackage

// File: rtl/matmult_mac.sv
// matmult_mac: one signed multiply-accumulate lane of the matmult tile.
// Optional feature macro: MATMULT_TILE_SAT_EN -- when defined every accumulate
// step saturates to the ACC_W signed range; otherwise the sum wraps.
module matmult_mac
    import matmult_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst_n_i,
    input  logic                     load_i,
    input  logic signed [ACC_W-1:0]  load_val_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  acc_o,
    output logic signed [ACC_W-1:0]  acc_nxt_o
);

    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    prod_ext_s;
    logic signed [ACC_W-1:0]    sum_s;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

`ifdef MATMULT_TILE_SAT_EN
    logic signed [SAT_MAX_W-1:0] sat_s;

    // Full-precision product, sign-extended, then clamped add onto the accumulator
    always_comb begin
        prod_s     = a_i * b_i;
        prod_ext_s = ACC_W'(prod_s);
        sat_s      = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(prod_ext_s), ACC_W);
        sum_s      = sat_s[ACC_W-1:0];
    end
`else
    // Full-precision product, sign-extended, then two's-complement wrapping add
    always_comb begin
        prod_s     = a_i * b_i;
        prod_ext_s = ACC_W'(prod_s);
        sum_s      = acc_q + prod_ext_s;
    end
`endif

    // Next accumulator value: load has priority over accumulate
    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = load_val_i;
        end else if (en_i) begin
            acc_d = sum_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o     = acc_q;
    assign acc_nxt_o = sum_s;

endmodule

// File: rtl/matmult_tile.sv
// matmult_tile: signed fixed-point C[M][N] = A[M][K] x B[K][N] tile with M*N
// parallel MAC lanes over K cycles, optional accumulate onto the previous C.
// Optional feature macro: MATMULT_TILE_SAT_EN (saturating accumulation in the
// lanes); the default build wraps modulo 2^ACC_W.
module matmult_tile
    import matmult_pkg::*;
#(
    parameter int   M      = 2,
    parameter int   N      = 2,
    parameter int   K      = 4,
    parameter int   DATA_W = 16,
    parameter int   ACC_W  = 40,
    localparam int  AW_A   = (M * K > 1) ? $clog2(M * K) : 1,
    localparam int  AW_B   = (K * N > 1) ? $clog2(K * N) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid,
    input  logic [AW_A-1:0]          addra,
    input  logic signed [DATA_W-1:0] inpa,
    input  logic [AW_B-1:0]          addrb,
    input  logic signed [DATA_W-1:0] inpb,
    input  logic                     start,
    input  logic                     accum,
    output logic [M*N*ACC_W-1:0]     c,
    output logic                     busy,
    output logic                     done
);

    localparam int             KW      = (K > 1) ? $clog2(K) : 1;
    localparam logic [KW-1:0]  K_LAST  = KW'(K - 1);
    localparam logic [AW_A:0]  A_DEPTH = (AW_A + 1)'(M * K);
    localparam logic [AW_B:0]  B_DEPTH = (AW_B + 1)'(K * N);

    // Operand buffers, row-major
    logic signed [DATA_W-1:0] a_q [M*K];
    logic signed [DATA_W-1:0] b_q [K*N];

    state_e              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic                busy_q, done_q;
    logic [M*N*ACC_W-1:0] c_q;

    logic                wr_en_s;
    logic                wa_s, wb_s;
    logic                lane_load_s;
    logic                lane_en_s;
    logic                c_upd_s;

    logic signed [DATA_W-1:0] a_sel_s [M];
    logic signed [DATA_W-1:0] b_sel_s [N];
    logic signed [ACC_W-1:0]  acc_s     [M*N];
    logic signed [ACC_W-1:0]  acc_nxt_s [M*N];

    // Controller next-state and per-cycle strobes
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        wr_en_s     = 1'b0;
        lane_load_s = 1'b0;
        lane_en_s   = 1'b0;
        c_upd_s     = 1'b0;
        case (state_q)
            IDLE: begin
                wr_en_s = valid;
                if (start) begin
                    state_d     = RUN;
                    k_d         = '0;
                    lane_load_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                lane_en_s = 1'b1;
                if (k_q == K_LAST) begin
                    c_upd_s = 1'b1;
                    state_d = DONE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    // Controller state, k counter and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    // Out-of-range addresses (non-power-of-two depths) never write
    always_comb begin
        wa_s = wr_en_s && ({1'b0, addra} < A_DEPTH);
        wb_s = wr_en_s && ({1'b0, addrb} < B_DEPTH);
    end

    // A/B operand buffers: written only while idle, kept across computations
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int x = 0; x < M * K; x++) begin
                a_q[x] <= '0;
            end
            for (int x = 0; x < K * N; x++) begin
                b_q[x] <= '0;
            end
        end else begin
            if (wa_s) begin
                a_q[addra] <= inpa;
            end else begin
                a_q[addra] <= a_q[addra];
            end
            if (wb_s) begin
                b_q[addrb] <= inpb;
            end else begin
                b_q[addrb] <= b_q[addrb];
            end
        end
    end

    // Column k of A and row k of B feed the lanes this cycle
    always_comb begin
        for (int i = 0; i < M; i++) begin
            a_sel_s[i] = a_q[i * K + int'(k_q)];
        end
        for (int j = 0; j < N; j++) begin
            b_sel_s[j] = b_q[int'(k_q) * N + j];
        end
    end

    // One MAC lane per C element
    for (genvar gi = 0; gi < M; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            localparam int LANE = c_lane(gi, gj, N);
            localparam int LSB  = c_lsb(gi, gj, N, ACC_W);

            logic signed [ACC_W-1:0] load_val_s;

            // Accumulate mode seeds the lane with the current result
            always_comb begin
                if (accum) begin
                    load_val_s = c_q[LSB +: ACC_W];
                end else begin
                    load_val_s = '0;
                end
            end

            matmult_mac #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_mac (
                .clk        (clk),
                .rst_n_i    (rst),
                .load_i     (lane_load_s),
                .load_val_i (load_val_s),
                .en_i       (lane_en_s),
                .a_i        (a_sel_s[gi]),
                .b_i        (b_sel_s[gj]),
                .acc_o      (acc_s[LANE]),
                .acc_nxt_o  (acc_nxt_s[LANE])
            );
        end
    end

    // Result register: captures the final lane sums on the last RUN cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            c_q <= '0;
        end else if (c_upd_s) begin
            for (int l = 0; l < M * N; l++) begin
                c_q[l*ACC_W +: ACC_W] <= acc_nxt_s[l];
            end
        end else begin
            c_q <= c_q;
        end
    end

    assign c    = c_q;
    assign busy = busy_q;
    assign done = done_q;

    // Current accumulators are observable only through c once published
    logic unused_acc_s;
    always_comb begin
        unused_acc_s = 1'b0;
        for (int l = 0; l < M * N; l++) begin
            unused_acc_s = unused_acc_s ^ (^acc_s[l]);
        end
    end

endmodule

// File: tb/tb_matmult_tile.sv
// tb_matmult_tile: directed self-checking bench for matmult_tile (M=N=2, K=4).
// Two instances share all inputs: default ACC_W=40 and a narrow ACC_W=32 one
// that exercises wrap/saturate on overflow.
module tb_matmult_tile;

    logic               clk;
    logic               rst;
    logic               valid;
    logic [2:0]         addra;
    logic signed [15:0] inpa;
    logic [2:0]         addrb;
    logic signed [15:0] inpb;
    logic               start;
    logic               accum;
    logic [159:0]       c;
    logic               busy;
    logic               done;
    logic [127:0]       c2;
    logic               busy2;
    logic               done2;

    int n_cmp = 0;
    int n_err = 0;

    matmult_tile dut (
        .clk(clk), .rst(rst), .valid(valid), .addra(addra), .inpa(inpa),
        .addrb(addrb), .inpb(inpb), .start(start), .accum(accum),
        .c(c), .busy(busy), .done(done)
    );

    matmult_tile #(.ACC_W(32)) dut32 (
        .clk(clk), .rst(rst), .valid(valid), .addra(addra), .inpa(inpa),
        .addrb(addrb), .inpb(inpb), .start(start), .accum(accum),
        .c(c2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint elem40(input int idx);
        logic signed [39:0] e;
        e = c[idx*40 +: 40];
        return longint'(e);
    endfunction

    function automatic longint elem32(input int idx);
        logic signed [31:0] e;
        e = c2[idx*32 +: 32];
        return longint'(e);
    endfunction

    task automatic chk_c(input string tag, input longint e0, input longint e1,
                         input longint e2, input longint e3);
        chk({tag, "_c00"}, elem40(0), e0);
        chk({tag, "_c01"}, elem40(1), e1);
        chk({tag, "_c10"}, elem40(2), e2);
        chk({tag, "_c11"}, elem40(3), e3);
        chk({tag, "_n_c00"}, elem32(0), e0);
        chk({tag, "_n_c11"}, elem32(3), e3);
    endtask

    // Load A and B in lockstep; the a/b arrays are row-major
    task automatic load_ab(input int av [8], input int bv [8]);
        for (int x = 0; x < 8; x++) begin
            valid = 1'b1;
            addra = 3'(x);
            addrb = 3'(x);
            inpa  = 16'(av[x]);
            inpb  = 16'(bv[x]);
            tick();
        end
        valid = 1'b0;
    endtask

    // Start a computation and count cycles until done (bounded)
    task automatic do_run(input logic acc_in, output int lat);
        start = 1'b1;
        accum = acc_in;
        tick();
        start = 1'b0;
        accum = 1'b0;
        chk("busy_t1", longint'(busy), 1);
        chk("done_t1", longint'(done), 0);
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    int a1 [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int b1 [8] = '{8, 7, 6, 5, 4, 3, 2, 1};
    int am [8] = '{-1, -1, -1, -1, -1, -1, -1, -1};
    int b3 [8] = '{3, 3, 3, 3, 3, 3, 3, 3};
    int mx [8] = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};

    initial begin
        int lat;
        int ndone;
        longint exp_n;

        rst   = 1'b0;
        valid = 1'b0;
        addra = 3'd0;
        addrb = 3'd0;
        inpa  = 16'sd0;
        inpb  = 16'sd0;
        start = 1'b0;
        accum = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        // Reset state
        chk("rst_c_zero", longint'(|c), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);

        // Scenario 1: basic product
        load_ab(a1, b1);
        do_run(1'b0, lat);
        chk("s1_latency", lat, 4);
        chk("s1_busy_done", longint'(busy), 1);
        chk_c("s1", 40, 30, 120, 94);
        tick();
        chk("s1_done_pulse", longint'(done), 0);
        chk("s1_idle_busy", longint'(busy), 0);

        // Scenario 2: accumulate onto previous result
        do_run(1'b1, lat);
        chk("s2_latency", lat, 4);
        chk_c("s2", 80, 60, 240, 188);
        tick();

        // Scenario 3: negative operands sign-extend
        load_ab(am, b3);
        do_run(1'b0, lat);
        chk("s3_latency", lat, 4);
        chk_c("s3", -12, -12, -12, -12);
        chk("s3_top_bits", longint'(c[159:120]), 40'hFF_FFFF_FFF4);
        tick();

        // Scenario 4: overflow on the narrow instance
        load_ab(mx, mx);
        do_run(1'b0, lat);
        chk("s4_latency", lat, 4);
        chk("s4_wide_c00", elem40(0), 64'sd4294705156);
        chk("s4_wide_c11", elem40(3), 64'sd4294705156);
`ifdef MATMULT_TILE_SAT_EN
        exp_n = 64'sd2147483647;
`else
        exp_n = -64'sd262140;
`endif
        chk("s4_narrow_c00", elem32(0), exp_n);
        chk("s4_narrow_c01", elem32(1), exp_n);
        chk("s4_narrow_c10", elem32(2), exp_n);
        chk("s4_narrow_c11", elem32(3), exp_n);
        tick();

        // Scenario 5: start and writes during RUN are ignored
        load_ab(a1, b1);
        start = 1'b1;
        tick();
        valid = 1'b1;
        addra = 3'd0;
        addrb = 3'd0;
        inpa  = 16'sd99;
        inpb  = 16'sd99;
        tick();
        tick();
        tick();
        start = 1'b0;
        valid = 1'b0;
        tick();
        chk("s5_done", longint'(done), 1);
        chk_c("s5", 40, 30, 120, 94);
        ndone = 0;
        for (int x = 0; x < 8; x++) begin
            tick();
            ndone += int'(done);
        end
        chk("s5_no_second_done", ndone, 0);
        do_run(1'b0, lat);
        chk("s5_rerun_latency", lat, 4);
        chk_c("s5r", 40, 30, 120, 94);
        tick();

        // Scenario 6: reset in the middle of RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("s6_c_zero", longint'(|c), 0);
        chk("s6_busy", longint'(busy), 0);
        chk("s6_done", longint'(done), 0);
        ndone = 0;
        for (int x = 0; x < 6; x++) begin
            tick();
            ndone += int'(done);
        end
        chk("s6_no_done", ndone, 0);
        do_run(1'b0, lat);
        chk("s6_zero_buf_latency", lat, 4);
        chk_c("s6z", 0, 0, 0, 0);
        tick();
        load_ab(a1, b1);
        do_run(1'b0, lat);
        chk("s6_reload_latency", lat, 4);
        chk_c("s6r", 40, 30, 120, 94);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
